pio_debounce_capture: RTL and testbench



---
 rtl/pio_debounce_capture.sv | 111 +++++++++++
 tb/tb_pio_debounce_capture.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pio_debounce_capture.sv
// Debounced parallel input port: per-bit 2-flop sync, stability counter, edge capture
// with write-1-to-clear, maskable level irq, Avalon-MM slave with 1-cycle read latency.
module pio_debounce_capture #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19,
   parameter int ACTIVE_LOW      = 1,
   parameter int EDGE_MODE       = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pio_in,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq
);

   typedef enum logic [1:0] {
      REG_DATA    = 2'd0,
      REG_IRQMASK = 2'd1,
      REG_EDGECAP = 2'd2,
      REG_RAW     = 2'd3
   } reg_addr_t;

   localparam logic [WIDTH-1:0] INV_MASK = {WIDTH{ACTIVE_LOW != 0}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam bit CAP_RISE = (EDGE_MODE == 0) || (EDGE_MODE == 2);
   localparam bit CAP_FALL = (EDGE_MODE == 1) || (EDGE_MODE == 2);

   logic [WIDTH-1:0] sync1, sync2, level;
   logic [WIDTH-1:0] stable, stable_next;
   logic [CNT_W-1:0] cnt      [WIDTH];
   logic [CNT_W-1:0] cnt_next [WIDTH];
   logic [WIDTH-1:0] irqmask, irqmask_next;
   logic [WIDTH-1:0] edgecap, edgecap_next;
   logic [WIDTH-1:0] edge_hit, clear_bits;
   logic [31:0]      rd_mux;
   reg_addr_t        reg_sel;
   logic             wr_en;
   logic             unused_wdata;

   // Synchroniser resets to the de-asserted pin level, so the logical level starts at 0.
   assign level        = sync2 ^ INV_MASK;
   assign reg_sel      = reg_addr_t'(address);
   assign wr_en        = chipselect & write;
   assign unused_wdata = ^writedata;

   // NOTE: combinational blocks use blocking '=' and give every output a default first,
   // so no latch can be inferred on any path.
   always_comb begin
      stable_next = stable;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_next[i] = '0;
         if (level[i] != stable[i]) begin
            if (cnt[i] == CNT_LAST) stable_next[i] = level[i];
            else                    cnt_next[i]    = cnt[i] + 1'b1;
         end
      end
   end

   always_comb begin
      edge_hit = '0;
      if (CAP_RISE) edge_hit = edge_hit | (stable_next & ~stable);
      if (CAP_FALL) edge_hit = edge_hit | (~stable_next & stable);
   end

   // A new edge in the same cycle as a W1C write to that bit wins over the clear.
   assign clear_bits   = (wr_en && reg_sel == REG_EDGECAP) ? writedata[WIDTH-1:0] : '0;
   assign edgecap_next = (edgecap & ~clear_bits) | edge_hit;
   assign irqmask_next = (wr_en && reg_sel == REG_IRQMASK) ? writedata[WIDTH-1:0] : irqmask;

   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         REG_DATA:    rd_mux[WIDTH-1:0] = stable;
         REG_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
         REG_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
         REG_RAW:     rd_mux[WIDTH-1:0] = level;
      endcase
   end

   // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1    <= INV_MASK;
         sync2    <= INV_MASK;
         stable   <= '0;
         // NOTE: the counter array is reset explicitly; a reset mid-debounce must
         // discard any partial count rather than leave it to finish early.
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
         irqmask  <= '0;
         edgecap  <= '0;
         readdata <= '0;
         irq      <= 1'b0;
      end else begin
         sync1    <= pio_in;
         sync2    <= sync1;
         stable   <= stable_next;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
         irqmask  <= irqmask_next;
         edgecap  <= edgecap_next;
         irq      <= |(edgecap_next & irqmask_next);
         if (chipselect && read) readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_pio_debounce_capture.sv
// Scoreboard bench: one instance capturing logical falling edges, one capturing both,
// sharing the board inputs and the Avalon bus.
module tb_pio_debounce_capture;

   localparam int WIDTH = 4;
   localparam int DB    = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] pio_in;
   logic [1:0]       address;
   logic             chipselect, read, write;
   logic [31:0]      writedata;
   logic [31:0]      readdata_f, readdata_b;
   logic             irq_f, irq_b;

   typedef struct {
      string       tag;
      logic [31:0] exp_f;
      logic [31:0] exp_b;
   } rd_exp_t;

   rd_exp_t sb[$];
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pio_debounce_capture #(
      .WIDTH(WIDTH), .DEBOUNCE_CYCLES(DB), .CNT_W(4), .ACTIVE_LOW(1), .EDGE_MODE(1)
   ) dut_f (
      .clk(clk), .reset(reset), .pio_in(pio_in), .address(address),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .readdata(readdata_f), .irq(irq_f)
   );

   pio_debounce_capture #(
      .WIDTH(WIDTH), .DEBOUNCE_CYCLES(DB), .CNT_W(4), .ACTIVE_LOW(1), .EDGE_MODE(2)
   ) dut_b (
      .clk(clk), .reset(reset), .pio_in(pio_in), .address(address),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .readdata(readdata_b), .irq(irq_b)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic check_irq(input string tag, input logic ef, input logic eb);
      check({tag, "_irq_f"}, {31'd0, irq_f}, {31'd0, ef});
      check({tag, "_irq_b"}, {31'd0, irq_b}, {31'd0, eb});
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_read(input logic [1:0] a, input string tag,
                           input logic [31:0] ef, input logic [31:0] eb);
      rd_exp_t e;
      @(negedge clk);
      chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
      e.tag = tag; e.exp_f = ef; e.exp_b = eb;
      sb.push_back(e);
      @(posedge clk);
      #2;
      chipselect = 1'b0; read = 1'b0;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
      @(posedge clk);
      #2;
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic bus_rw(input logic [1:0] a, input logic [31:0] d, input string tag,
                         input logic [31:0] ef, input logic [31:0] eb);
      rd_exp_t e;
      @(negedge clk);
      chipselect = 1'b1; write = 1'b1; read = 1'b1; address = a; writedata = d;
      e.tag = tag; e.exp_f = ef; e.exp_b = eb;
      sb.push_back(e);
      @(posedge clk);
      #2;
      chipselect = 1'b0; write = 1'b0; read = 1'b0;
   endtask

   // Read data is valid just after the edge that accepted the read strobe.
   always @(posedge clk) begin
      rd_exp_t e;
      if (chipselect && read && !reset) begin
         #1;
         check("sb_pending", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "_f"}, readdata_f, e.exp_f);
            check({e.tag, "_b"}, readdata_b, e.exp_b);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; pio_in = 4'hF; address = 2'd0;
      chipselect = 1'b0; read = 1'b0; write = 1'b0; writedata = 32'h0;
      tick(3);
      reset = 1'b0;

      // Reset state and no spurious capture afterwards
      check("rst_readdata_f", readdata_f, 32'h0);
      check("rst_readdata_b", readdata_b, 32'h0);
      check_irq("rst", 1'b0, 1'b0);
      bus_read(2'd0, "rst_data", 32'h0, 32'h0);
      bus_read(2'd1, "rst_mask", 32'h0, 32'h0);
      bus_read(2'd3, "rst_raw",  32'h0, 32'h0);
      for (int i = 0; i < 20; i++) bus_read(2'd2, "post_rst_ec", 32'h0, 32'h0);

      // Clean press on bit 1: a logical rise, seen only by the both-edges instance
      @(negedge clk); pio_in[1] = 1'b0;
      tick(DB);
      bus_read(2'd0, "press_data_early", 32'h0, 32'h0);
      bus_read(2'd0, "press_data",       32'h2, 32'h2);
      bus_read(2'd2, "press_ec",         32'h0, 32'h2);
      check_irq("press_nomask", 1'b0, 1'b0);
      bus_write(2'd1, 32'h2);
      check_irq("press_mask", 1'b0, 1'b1);
      bus_write(2'd1, 32'hFFFF_FFF3);
      bus_read(2'd1, "mask_upper", 32'h3, 32'h3);
      bus_write(2'd0, 32'hFFFF_FFFF);
      bus_read(2'd0, "data_ro", 32'h2, 32'h2);

      // Glitches on bit 2: 5 cycles with RAW observed, then DB-1 cycles
      @(negedge clk); pio_in[2] = 1'b0;
      tick(1);
      bus_read(2'd3, "glitch_raw", 32'h6, 32'h6);
      tick(3); pio_in[2] = 1'b1;
      tick(20);
      bus_read(2'd3, "glitch_raw_after", 32'h2, 32'h2);
      @(negedge clk); pio_in[2] = 1'b0;
      tick(DB - 1); pio_in[2] = 1'b1;
      tick(20);
      bus_read(2'd0, "glitch_data", 32'h2, 32'h2);
      bus_read(2'd2, "glitch_ec",   32'h0, 32'h2);

      // Clear, then release bit 1: a logical fall, seen by both instances
      bus_write(2'd2, 32'h2);
      check_irq("ec_clr", 1'b0, 1'b0);
      bus_read(2'd2, "ec_clr", 32'h0, 32'h0);
      @(negedge clk); pio_in[1] = 1'b1;
      tick(DB);
      bus_read(2'd0, "rel_data_early", 32'h2, 32'h2);
      bus_read(2'd0, "rel_data",       32'h0, 32'h0);
      bus_read(2'd2, "rel_ec",         32'h2, 32'h2);
      check_irq("rel", 1'b1, 1'b1);
      bus_write(2'd2, 32'hF);
      check_irq("rel_clr", 1'b0, 1'b0);
      bus_read(2'd2, "rel_ec_clr", 32'h0, 32'h0);

      // W1C racing a capture on bit 0: set must win
      @(negedge clk); pio_in[0] = 1'b0;
      tick(20);
      bus_read(2'd2, "p0_ec", 32'h0, 32'h1);
      check_irq("p0", 1'b0, 1'b1);
      bus_write(2'd2, 32'h1);
      bus_read(2'd2, "p0_ec_clr", 32'h0, 32'h0);
      @(negedge clk); pio_in[0] = 1'b1;
      tick(DB);
      bus_write(2'd2, 32'h1);
      check_irq("race", 1'b1, 1'b1);
      bus_read(2'd2, "race_ec", 32'h1, 32'h1);
      check_irq("race_hold", 1'b1, 1'b1);
      bus_rw(2'd2, 32'h1, "rw_ec_prewrite", 32'h1, 32'h1);
      check_irq("race_clr", 1'b0, 1'b0);
      bus_read(2'd2, "race_ec_clr", 32'h0, 32'h0);

      // Reset at count 5 of a bit-3 press; full latency restarts from release
      @(negedge clk); pio_in[3] = 1'b0;
      tick(7);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      check("mid_rst_readdata", readdata_f, 32'h0);
      tick(DB);
      bus_read(2'd0, "mid_rst_early", 32'h0, 32'h0);
      bus_read(2'd0, "mid_rst_data",  32'h8, 32'h8);
      bus_read(2'd2, "mid_rst_ec",    32'h0, 32'h8);
      bus_read(2'd1, "mid_rst_mask",  32'h0, 32'h0);
      check_irq("mid_rst", 1'b0, 1'b0);

      tick(2);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
